line_tap_buffer: RTL and testbench

//  Multi-line delay buffer for windowed video filters.
//  - Accepts one pixel per valid cycle.
//  - Presents the current pixel plus TAPS vertically aligned pixels from the previous TAPS lines.
//  - Sits between DVP capture/colour conversion and 3x3/5x5 kernels (Sobel, median, Gaussian).
//  - Adds over a fixed single-line shift RAM: runtime line length, valid gaps, frame restart and top-border fill.

---
 rtl/line_tap_buffer_pkg.sv | 22 ++
 rtl/line_tap_buffer_if.sv | 32 +++
 rtl/line_tap_buffer_sdp_ram.sv | 37 +++
 rtl/line_tap_buffer.sv | 129 ++++++++++++
 tb/tb_line_tap_buffer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/line_tap_buffer_pkg.sv
// Shared video definitions for the line tap buffer.
package line_tap_buffer_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned MAX_LINE_DEF   = 1280;
    localparam int unsigned TAPS_DEF       = 2;

    // Fill policy for taps that have no previous line behind them yet
    localparam int unsigned BORDER_ZERO = 0;
    localparam int unsigned BORDER_REPL = 1;

    // Runtime line length limited to [2, max_line] so read and write addresses never collide
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_line);
        if (len < 2) begin
            return 2;
        end else if (len > max_line) begin
            return max_line;
        end
        return len;
    endfunction

endpackage

// File: rtl/line_tap_buffer_if.sv
// Pixel-in / window-out bundle of the line tap buffer.
interface line_tap_buffer_if
    import line_tap_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned MAX_LINE   = MAX_LINE_DEF,
    parameter int unsigned TAPS       = TAPS_DEF
);
    localparam int unsigned LEN_W  = $clog2(MAX_LINE + 1);
    localparam int unsigned ROWS_W = $clog2(TAPS + 1);

    logic [LEN_W-1:0]           line_len;
    logic                       in_valid;
    logic                       in_sof;
    logic [DATA_WIDTH-1:0]      in_data;
    logic                       out_valid;
    logic [DATA_WIDTH-1:0]      out_data;
    logic [TAPS*DATA_WIDTH-1:0] out_taps;
    logic                       out_eol;
    logic [ROWS_W-1:0]          out_rows;

    modport master (
        output line_len, in_valid, in_sof, in_data,
        input  out_valid, out_data, out_taps, out_eol, out_rows
    );

    modport slave (
        input  line_len, in_valid, in_sof, in_data,
        output out_valid, out_data, out_taps, out_eol, out_rows
    );

endinterface

// File: rtl/line_tap_buffer_sdp_ram.sv
// Simple dual-port line RAM: registered read-first output, array not reset.
module lb_sdp_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 1280,
    parameter int unsigned ADDR_W     = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Storage array write port
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register holds its value between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/line_tap_buffer.sv
// Multi-line delay buffer: current pixel plus TAPS vertically aligned pixels above it.
module line_tap_buffer
    import line_tap_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned MAX_LINE   = MAX_LINE_DEF,
    parameter int unsigned TAPS       = TAPS_DEF,
    parameter int unsigned BORDER     = BORDER_ZERO
) (
    input logic              clk,
    input logic              rst_n,
    line_tap_buffer_if.slave bus
);
    localparam int unsigned LEN_W  = $clog2(MAX_LINE + 1);
    localparam int unsigned COL_W  = $clog2(MAX_LINE);
    localparam int unsigned ROWS_W = $clog2(TAPS + 1);

    logic [COL_W-1:0]           col_q, col_d, pix_col, wr_addr_q;
    logic [LEN_W-1:0]           len_q, len_d, pix_len;
    logic [ROWS_W-1:0]          rows_q, rows_d, pix_rows, rows_out_q;
    logic                       pix_eol, eol_q, valid_q;
    logic [DATA_WIDTH-1:0]      data_q;
    logic [DATA_WIDTH-1:0]      ram_rd [TAPS];
    logic [DATA_WIDTH-1:0]      ram_wd [TAPS];
    logic [TAPS*DATA_WIDTH-1:0] taps;
    int unsigned                repl_idx;

    // Position of the incoming pixel; sof overrides column, rows and line length
    always_comb begin
        pix_col  = bus.in_sof ? '0 : col_q;
        pix_rows = bus.in_sof ? '0 : rows_q;
        pix_len  = bus.in_sof ? LEN_W'(clamp_len(32'(bus.line_len), MAX_LINE)) : len_q;
        pix_eol  = (LEN_W'(pix_col) == pix_len - LEN_W'(1));
        col_d    = col_q;
        rows_d   = rows_q;
        len_d    = len_q;
        if (bus.in_valid) begin
            len_d = pix_len;
            if (pix_eol) begin
                col_d  = '0;
                rows_d = (pix_rows == ROWS_W'(TAPS)) ? pix_rows : pix_rows + ROWS_W'(1);
            end else begin
                col_d  = pix_col + COL_W'(1);
                rows_d = pix_rows;
            end
        end
    end

    // Column, filled-row and line-length state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            rows_q <= '0;
            len_q  <= LEN_W'(MAX_LINE);
        end else begin
            col_q  <= col_d;
            rows_q <= rows_d;
            len_q  <= len_d;
        end
    end

    // Output stage; also the delayed write address/data for the line RAMs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            wr_addr_q  <= '0;
            rows_out_q <= '0;
            eol_q      <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                data_q     <= bus.in_data;
                wr_addr_q  <= pix_col;
                rows_out_q <= pix_rows;
                eol_q      <= pix_eol;
            end
        end
    end

    // Line RAM chain: each RAM pushes the row it just read one line further down
    for (genvar k = 0; k < TAPS; k++) begin : g_line
        if (k == 0) begin : g_first
            assign ram_wd[k] = data_q;
        end else begin : g_chain
            assign ram_wd[k] = ram_rd[k-1];
        end

        lb_sdp_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (MAX_LINE),
            .ADDR_W     (COL_W)
        ) u_ram (
            .clk       (clk),
            .rst_n     (rst_n),
            .rd_en_i   (bus.in_valid),
            .rd_addr_i (pix_col),
            .rd_data_o (ram_rd[k]),
            .wr_en_i   (valid_q),
            .wr_addr_i (wr_addr_q),
            .wr_data_i (ram_wd[k])
        );
    end

    // Tap masking: unfilled taps read zero or replicate the oldest filled row
    always_comb begin
        taps     = '0;
        repl_idx = 0;
        for (int unsigned k = 0; k < TAPS; k++) begin
            if (k < 32'(rows_out_q)) begin
                taps[k*DATA_WIDTH +: DATA_WIDTH] = ram_rd[k];
            end else if (BORDER == BORDER_REPL) begin
                if (rows_out_q == '0) begin
                    taps[k*DATA_WIDTH +: DATA_WIDTH] = data_q;
                end else begin
                    repl_idx = 32'(rows_out_q) - 1;
                    taps[k*DATA_WIDTH +: DATA_WIDTH] = ram_rd[repl_idx];
                end
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_taps  = taps;
    assign bus.out_eol   = eol_q;
    assign bus.out_rows  = rows_out_q;

endmodule

// File: tb/tb_line_tap_buffer.sv
// Directed bench: two buffers (zero fill and replicate fill) driven with identical pixels.
module tb_line_tap_buffer;
    import line_tap_buffer_pkg::*;

    logic clk;
    logic rst_n;
    int   passed;
    int   failed;
    int   total;

    line_tap_buffer_if #(.DATA_WIDTH(8), .MAX_LINE(1280), .TAPS(2)) bus0 ();
    line_tap_buffer_if #(.DATA_WIDTH(8), .MAX_LINE(1280), .TAPS(2)) bus1 ();

    line_tap_buffer #(.DATA_WIDTH(8), .MAX_LINE(1280), .TAPS(2), .BORDER(BORDER_ZERO)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    line_tap_buffer #(.DATA_WIDTH(8), .MAX_LINE(1280), .TAPS(2), .BORDER(BORDER_REPL)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_len(input logic [10:0] len);
        bus0.line_len = len;
        bus1.line_len = len;
    endtask

    // One accepted pixel; returns 1 time unit after the accepting edge
    task automatic send(input logic sof, input logic [7:0] d);
        bus0.in_valid = 1'b1; bus0.in_sof = sof; bus0.in_data = d;
        bus1.in_valid = 1'b1; bus1.in_sof = sof; bus1.in_data = d;
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0; bus0.in_sof = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_sof = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pix(input string tag, input logic [7:0] d, input logic [1:0] rows,
                           input logic eol, input logic [15:0] t_b0, input logic [15:0] t_b1);
        chk({tag, ".valid0"}, 32'(bus0.out_valid), 32'd1);
        chk({tag, ".valid1"}, 32'(bus1.out_valid), 32'd1);
        chk({tag, ".data"},   32'(bus0.out_data),  32'(d));
        chk({tag, ".rows"},   32'(bus0.out_rows),  32'(rows));
        chk({tag, ".eol"},    32'(bus0.out_eol),   32'(eol));
        chk({tag, ".taps0"},  32'(bus0.out_taps),  32'(t_b0));
        chk({tag, ".taps1"},  32'(bus1.out_taps),  32'(t_b1));
    endtask

    // Expected taps when pixel value p is the p-th pixel of a frame with line length len
    function automatic logic [15:0] exp_taps(input int p, input int len, input bit repl);
        int line;
        int rows;
        logic [7:0] t0;
        logic [7:0] t1;
        line = (p - 1) / len;
        rows = (line > 2) ? 2 : line;
        t0 = (rows >= 1) ? 8'(p - len) : 8'd0;
        t1 = (rows >= 2) ? 8'(p - 2 * len) : 8'd0;
        if (repl) begin
            if (rows == 0) begin
                t0 = 8'(p);
                t1 = 8'(p);
            end else if (rows == 1) begin
                t1 = t0;
            end
        end
        return {t1, t0};
    endfunction

    function automatic logic [1:0] exp_rows(input int p, input int len);
        int line;
        line = (p - 1) / len;
        return (line > 2) ? 2'd2 : 2'(line);
    endfunction

    initial begin
        int eol_count;
        passed = 0;
        failed = 0;
        total  = 0;
        rst_n  = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_sof = 1'b0; bus0.in_data = '0;
        bus1.in_valid = 1'b0; bus1.in_sof = 1'b0; bus1.in_data = '0;
        set_len(11'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset.valid", 32'(bus0.out_valid), 32'd0);
        chk("reset.data",  32'(bus0.out_data),  32'd0);
        chk("reset.taps0", 32'(bus0.out_taps),  32'd0);
        chk("reset.taps1", 32'(bus1.out_taps),  32'd0);
        chk("reset.rows",  32'(bus0.out_rows),  32'd0);
        chk("reset.eol",   32'(bus0.out_eol),   32'd0);
        rst_n = 1'b1;
        idle();

        // Line length 4, pixels 1..12, back to back
        set_len(11'd4);
        for (int p = 1; p <= 12; p++) begin
            send(p == 1, 8'(p));
            chk_pix($sformatf("t1.p%0d", p), 8'(p), exp_rows(p, 4), (p % 4) == 0,
                    exp_taps(p, 4, 1'b0), exp_taps(p, 4, 1'b1));
        end

        // Same frame with random idle gaps; idle cycles must hold the last column
        for (int p = 1; p <= 12; p++) begin
            if ($urandom_range(0, 1) == 1) begin
                idle();
                chk($sformatf("t3.idle%0d.valid", p), 32'(bus0.out_valid), 32'd0);
                chk($sformatf("t3.idle%0d.data", p),  32'(bus0.out_data), 32'((p == 1) ? 12 : p - 1));
                chk($sformatf("t3.idle%0d.taps", p),  32'(bus0.out_taps),
                    32'(exp_taps((p == 1) ? 12 : p - 1, 4, 1'b0)));
            end
            send(p == 1, 8'(p));
            chk_pix($sformatf("t3.p%0d", p), 8'(p), exp_rows(p, 4), (p % 4) == 0,
                    exp_taps(p, 4, 1'b0), exp_taps(p, 4, 1'b1));
        end

        // Line length 3, sof arriving at column 2 of the second line
        set_len(11'd3);
        send(1'b1, 8'd31); chk_pix("t4.p31", 8'd31, 2'd0, 1'b0, 16'h0000, {8'd31, 8'd31});
        send(1'b0, 8'd32); chk_pix("t4.p32", 8'd32, 2'd0, 1'b0, 16'h0000, {8'd32, 8'd32});
        send(1'b0, 8'd33); chk_pix("t4.p33", 8'd33, 2'd0, 1'b1, 16'h0000, {8'd33, 8'd33});
        send(1'b0, 8'd34); chk_pix("t4.p34", 8'd34, 2'd1, 1'b0, {8'd0, 8'd31}, {8'd31, 8'd31});
        send(1'b0, 8'd35); chk_pix("t4.p35", 8'd35, 2'd1, 1'b0, {8'd0, 8'd32}, {8'd32, 8'd32});
        send(1'b1, 8'd36); chk_pix("t4.p36", 8'd36, 2'd0, 1'b0, 16'h0000, {8'd36, 8'd36});
        send(1'b0, 8'd37); chk_pix("t4.p37", 8'd37, 2'd0, 1'b0, 16'h0000, {8'd37, 8'd37});
        send(1'b0, 8'd38); chk_pix("t4.p38", 8'd38, 2'd0, 1'b1, 16'h0000, {8'd38, 8'd38});
        send(1'b0, 8'd39); chk_pix("t4.p39", 8'd39, 2'd1, 1'b0, {8'd0, 8'd36}, {8'd36, 8'd36});

        // Line length 1 clamps to 2
        set_len(11'd1);
        send(1'b1, 8'hA1); chk_pix("t5a.p1", 8'hA1, 2'd0, 1'b0, 16'h0000, {8'hA1, 8'hA1});
        send(1'b0, 8'hA2); chk_pix("t5a.p2", 8'hA2, 2'd0, 1'b1, 16'h0000, {8'hA2, 8'hA2});
        send(1'b0, 8'hA3); chk_pix("t5a.p3", 8'hA3, 2'd1, 1'b0, {8'h00, 8'hA1}, {8'hA1, 8'hA1});

        // Line length 2000 clamps to 1280
        set_len(11'd2000);
        eol_count = 0;
        for (int i = 0; i < 1280; i++) begin
            send(i == 0, 8'(i + 3));
            if (bus0.out_eol) eol_count++;
            if (i == 1278) chk("t5b.eol1278", 32'(bus0.out_eol), 32'd0);
            if (i == 1279) chk("t5b.eol1279", 32'(bus0.out_eol), 32'd1);
        end
        chk("t5b.eol_count", 32'(eol_count), 32'd1);
        set_len(11'd4);
        send(1'b0, 8'hEE); chk_pix("t5b.next", 8'hEE, 2'd1, 1'b0, {8'h00, 8'h03}, {8'h03, 8'h03});

        // Asynchronous reset in the third line
        for (int p = 1; p <= 10; p++) begin
            send(p == 1, 8'(p + 8'h50));
        end
        chk_pix("t6.pre", 8'h5A, 2'd2, 1'b0, {8'h52, 8'h56}, {8'h52, 8'h56});
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.rst.valid", 32'(bus0.out_valid), 32'd0);
        chk("t6.rst.data",  32'(bus0.out_data),  32'd0);
        chk("t6.rst.taps0", 32'(bus0.out_taps),  32'd0);
        chk("t6.rst.taps1", 32'(bus1.out_taps),  32'd0);
        chk("t6.rst.rows",  32'(bus0.out_rows),  32'd0);
        chk("t6.rst.eol",   32'(bus0.out_eol),   32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        send(1'b0, 8'h77); chk_pix("t6.p77", 8'h77, 2'd0, 1'b0, 16'h0000, {8'h77, 8'h77});
        send(1'b0, 8'h78);
        send(1'b0, 8'h79);
        send(1'b0, 8'h7A); chk_pix("t6.p7A", 8'h7A, 2'd0, 1'b0, 16'h0000, {8'h7A, 8'h7A});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
